// File: rtl/spi_peripheral_pkg.sv
// Shared constants for the SPI peripheral: word width, FSM state encodings
// and the supported SPI mode.
package spi_peripheral_pkg;

  localparam int W_CPU = 32;

  localparam logic SPI_IDLE  = 1'b0;
  localparam logic SPI_SHIFT = 1'b1;

  // {CPOL, CPHA}: mode 0 only.
  localparam logic [1:0] SPI_MODE = 2'b00;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser plus history flop for one asynchronous SPI pin,
// with single-cycle rise/fall strobes in the clk domain.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic hist;

  // NOTE: flops are written with <= so every stage samples its pre-edge input;
  // with = the three stages would collapse into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI slave oversampled in the clk domain: shifts W_Data-bit words in
// on MOSI and out on MISO, with valid/ready handshakes towards the core.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int W_Data    = W_CPU,
  parameter int W_Counter = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              MOSI_in,
  output logic              MISO_out,
  output logic              MISO_oe,
  input  logic [W_Data-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [W_Data-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam logic [W_Counter-1:0] CNT_MAX = W_Counter'(W_Data - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  // Idle levels: spi_clk low, cs_n high, so leaving reset never fakes an edge.
  spi_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(spi_clk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(MOSI_in),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused;
  assign unused = ^{sclk_sync, cs_sync, mosi_rise, mosi_fall};

  logic                 state;
  logic [W_Data-1:0]    tx_hold;
  logic                 hold_full;
  logic [W_Data-1:0]    tx_shift;
  logic [W_Data-2:0]    rx_shift;
  logic [W_Data-1:0]    rx_next;
  logic [W_Counter-1:0] bit_cnt;
  logic                 word_done;
  logic                 load_word;
  logic                 handshake;

  assign rx_next   = {rx_shift, mosi_sync};
  assign handshake = tx_valid & tx_ready;
  assign tx_ready  = ~hold_full;
  assign MISO_out  = tx_shift[W_Data-1];
  assign MISO_oe   = (state == SPI_SHIFT);

  // A word is loaded into the shifter at frame start, or on the falling edge
  // that follows a completed word; a simultaneous cs_rise wins over that edge.
  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves the
    // signal unassigned and infers a latch.
    load_word = 1'b0;
    if (state == SPI_IDLE) load_word = cs_fall;
    else                   load_word = ~cs_rise & sclk_fall & word_done;
  end

  // NOTE: the holding register is reset along with its flag; it is only a
  // single word, so there is no reason to leave it X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold   <= '0;
      hold_full <= 1'b0;
    end else if (handshake) begin
      tx_hold   <= tx_data;
      hold_full <= 1'b1;
    end else if (load_word) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SPI_IDLE;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      bit_cnt     <= CNT_MAX;
      word_done   <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (load_word) begin
        tx_shift    <= hold_full ? tx_hold : '0;
        tx_underrun <= ~hold_full;
        bit_cnt     <= CNT_MAX;
        word_done   <= 1'b0;
      end

      if (state == SPI_IDLE) begin
        if (cs_fall) state <= SPI_SHIFT;
      end else if (cs_rise) begin
        state       <= SPI_IDLE;
        bit_cnt     <= CNT_MAX;
        word_done   <= 1'b0;
        frame_abort <= ~word_done & (bit_cnt != CNT_MAX);
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_next[W_Data-2:0];
          if (bit_cnt == '0) begin
            rx_data   <= rx_next;
            rx_valid  <= 1'b1;
            word_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        if (sclk_fall && !word_done) tx_shift <= tx_shift << 1;
      end
    end
  end

endmodule
